int_to_float_scheduler: RTL and testbench

- Shares one pipelined IntToFloat converter (fixed latency 4, one conversion per clock, no valid/ready of its own) between NUM_REQ requesters.
- Each requester has a valid/ready request port. The block arbitrates round-robin, or fixed-priority when configured, and issues at most one integer per cycle.
- It tracks requester IDs through a tag pipeline aligned with the converter and returns each result on a shared, tagged result bus.
- Sits between the integer producers (e.g. vertex/attribute fetch) and the float datapath.

---
 rtl/float_pkg.sv | 16 +
 rtl/int_to_float_scheduler_pkg.sv | 29 ++
 rtl/int_to_float.sv | 102 ++++++++++
 rtl/int_to_float_scheduler_rr_arbiter.sv | 46 ++++
 rtl/int_to_float_scheduler.sv | 122 ++++++++++++
 tb/tb_int_to_float_scheduler.sv | 249 ++++++++++++++++++++++++
 6 files changed

// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : float_pkg
//  Description : Float format sizes shared by the integer-to-float datapath
//                and the converter latency the scheduler must track.
//  Revision    : 1.0 - initial release
// ============================================================================
package float_pkg;

    localparam int DEFAULT_MANTISSA_SIZE     = 23;
    localparam int DEFAULT_EXPONENT_SIZE     = 8;
    localparam int FLOAT_SIZE                = 1 + DEFAULT_EXPONENT_SIZE + DEFAULT_MANTISSA_SIZE;
    localparam int CONV_LATENCY_INT_TO_FLOAT = 4;

endpackage
`default_nettype wire

// File: rtl/int_to_float_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_to_float_scheduler_pkg
//  Description : Arbitration mode encoding and the explicit modulo helper
//                used by the scheduler and its arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package int_to_float_scheduler_pkg;

    typedef enum logic {
        ARB_ROUND_ROBIN    = 1'b0,
        ARB_FIXED_PRIORITY = 1'b1
    } arb_mode_e;

    // (a + b) mod n for a, b < n; a compare-and-subtract so that
    // non-power-of-two requester counts wrap correctly.
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_to_float.sv
`default_nettype none
// ============================================================================
//  Module      : int_to_float
//  Description : Pipelined signed integer to IEEE-style float converter.
//                Four register stages, one conversion per clock, rounding
//                to nearest-even. No reset: data is never qualified here.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_to_float #(
    parameter int INT_SIZE      = 32,
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8
) (
    input  logic                                   clk,
    input  logic [INT_SIZE-1:0]                    i_int,
    output logic [EXPONENT_SIZE+MANTISSA_SIZE:0]   o_float
);

    localparam int c_LZ_W    = $clog2(INT_SIZE + 1);
    localparam int c_BIAS    = (1 << (EXPONENT_SIZE - 1)) - 1;
    localparam int c_EXP_TOP = c_BIAS + INT_SIZE - 1;
    localparam int c_EM_W    = EXPONENT_SIZE + MANTISSA_SIZE;

    logic                     r_s1_sign;
    logic [INT_SIZE-1:0]      r_s1_mag;
    logic                     r_s2_sign;
    logic [INT_SIZE-1:0]      r_s2_mag;
    logic [c_LZ_W-1:0]        r_s2_lz;
    logic                     r_s3_sign;
    logic [INT_SIZE-1:0]      r_s3_norm;
    logic [EXPONENT_SIZE-1:0] r_s3_exp;

    logic [c_LZ_W-1:0]        w_lz;
    logic [EXPONENT_SIZE-1:0] w_exp;
    logic [MANTISSA_SIZE-1:0] w_mant;
    logic                     w_guard;
    logic                     w_sticky;
    logic                     w_round_up;
    logic [c_EM_W-1:0]        w_sum;

    // Stage 1: split sign and magnitude (most negative value maps to 2^(N-1)).
    always_ff @(posedge clk) begin
        r_s1_sign <= i_int[INT_SIZE-1];
        r_s1_mag  <= i_int[INT_SIZE-1] ? ((~i_int) + INT_SIZE'(1)) : i_int;
    end

    // Leading-zero count of the magnitude; a zero magnitude counts INT_SIZE.
    always_comb begin
        logic found;
        found = 1'b0;
        w_lz  = c_LZ_W'(INT_SIZE);
        for (int i = INT_SIZE - 1; i >= 0; i--) begin
            if (!found && r_s1_mag[i]) begin
                w_lz  = c_LZ_W'(INT_SIZE - 1 - i);
                found = 1'b1;
            end
        end
    end

    // Stage 2: hold magnitude with its leading-zero count.
    always_ff @(posedge clk) begin
        r_s2_sign <= r_s1_sign;
        r_s2_mag  <= r_s1_mag;
        r_s2_lz   <= w_lz;
    end

    // Biased exponent of the normalized value.
    always_comb begin
        w_exp = EXPONENT_SIZE'(c_EXP_TOP - int'(r_s2_lz));
    end

    // Stage 3: normalize so the leading one sits in the MSB; the MSB then
    // doubles as the non-zero flag.
    always_ff @(posedge clk) begin
        r_s3_sign <= r_s2_sign;
        r_s3_norm <= r_s2_mag << r_s2_lz;
        r_s3_exp  <= w_exp;
    end

    generate
        if (INT_SIZE > MANTISSA_SIZE + 2) begin : g_sticky
            assign w_sticky = |r_s3_norm[INT_SIZE-3-MANTISSA_SIZE:0];
        end else begin : g_no_sticky
            assign w_sticky = 1'b0;
        end
    endgenerate

    // Round to nearest-even; a mantissa carry ripples into the exponent.
    always_comb begin
        w_mant     = r_s3_norm[INT_SIZE-2 -: MANTISSA_SIZE];
        w_guard    = r_s3_norm[INT_SIZE-2-MANTISSA_SIZE];
        w_round_up = w_guard & (w_sticky | w_mant[0]);
        w_sum      = {r_s3_exp, w_mant} + c_EM_W'(w_round_up);
    end

    // Stage 4: pack; zero input yields +0.0.
    always_ff @(posedge clk) begin
        o_float <= r_s3_norm[INT_SIZE-1] ? {r_s3_sign, w_sum} : '0;
    end

endmodule
`default_nettype wire

// File: rtl/int_to_float_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin / fixed-priority arbiter. The
//                search starts at the supplied pointer (round-robin) or at
//                index 0 (fixed priority); the first requesting index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import int_to_float_scheduler_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] pointer,
    input  logic             fixed_priority,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    int unsigned w_cand;

    // Scan all N candidates from the start point, taking the first request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_cand    = 0;
        for (int k = 0; k < N; k++) begin
            if (arb_mode_e'(fixed_priority) == ARB_FIXED_PRIORITY) begin
                w_cand = unsigned'(k);
            end else begin
                w_cand = wrap_add(int'(pointer), unsigned'(k), unsigned'(N));
            end
            if (!any_grant && req[w_cand[IDX_W-1:0]]) begin
                any_grant                   = 1'b1;
                grant_idx                   = w_cand[IDX_W-1:0];
                grant[w_cand[IDX_W-1:0]]    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/int_to_float_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : int_to_float_scheduler
//  Description : Shares one pipelined int-to-float converter among NUM_REQ
//                valid/ready requesters. Issues at most one integer per
//                cycle and tags each conversion with its requester ID
//                through a pipeline aligned with the converter latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_to_float_scheduler
    import float_pkg::*;
    import int_to_float_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int INT_SIZE      = 32,
    parameter int MANTISSA_SIZE = DEFAULT_MANTISSA_SIZE,
    parameter int EXPONENT_SIZE = DEFAULT_EXPONENT_SIZE,
    parameter int CONV_LATENCY  = CONV_LATENCY_INT_TO_FLOAT,
    parameter int ID_SIZE       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cfg_fixed_priority,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*INT_SIZE-1:0]           req_data,
    output logic                                  res_valid,
    output logic [ID_SIZE-1:0]                    res_id,
    output logic [EXPONENT_SIZE+MANTISSA_SIZE:0]  res_data,
    output logic                                  busy
);

    typedef struct packed {
        logic               valid;
        logic [ID_SIZE-1:0] id;
    } tag_t;

    logic [ID_SIZE-1:0]  r_ptr;
    logic [INT_SIZE-1:0] r_conv_in;
    tag_t                r_tag [0:CONV_LATENCY];

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_SIZE-1:0]  w_grant_idx;
    logic                w_any_grant;
    logic                w_fire;
    arb_mode_e           w_mode;

    assign w_mode = arb_mode_e'(cfg_fixed_priority);

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_SIZE)
    ) u_arbiter (
        .req            (req_valid),
        .pointer        (r_ptr),
        .fixed_priority (cfg_fixed_priority),
        .grant          (w_grant),
        .grant_idx      (w_grant_idx),
        .any_grant      (w_any_grant)
    );

    // Grants are suppressed while reset is held so nothing is accepted then.
    always_comb begin
        w_fire    = w_any_grant & ~reset;
        req_ready = reset ? '0 : w_grant;
    end

    // Round-robin pointer moves past the winner; fixed-priority leaves it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_fire && (w_mode == ARB_ROUND_ROBIN)) begin
            r_ptr <= ID_SIZE'(wrap_add(int'(w_grant_idx), 1, unsigned'(NUM_REQ)));
        end
    end

    // Converter input register: captures the winner's data, else holds.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_conv_in <= req_data[w_grant_idx*INT_SIZE +: INT_SIZE];
        end
    end

    // Tag pipeline: stage 0 sits beside the input register, the remaining
    // CONV_LATENCY stages shift unconditionally alongside the converter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= CONV_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0].valid <= w_fire;
            r_tag[0].id    <= w_fire ? w_grant_idx : '0;
            for (int i = 1; i <= CONV_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    int_to_float #(
        .INT_SIZE      (INT_SIZE),
        .MANTISSA_SIZE (MANTISSA_SIZE),
        .EXPONENT_SIZE (EXPONENT_SIZE)
    ) u_conv (
        .clk     (clk),
        .i_int   (r_conv_in),
        .o_float (res_data)
    );

    // Busy while any tag stage, including the issue stage, holds a valid.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= CONV_LATENCY; i++) begin
            busy = busy | r_tag[i].valid;
        end
    end

    assign res_valid = r_tag[CONV_LATENCY].valid;
    assign res_id    = r_tag[CONV_LATENCY].id;

endmodule
`default_nettype wire

// File: tb/tb_int_to_float_scheduler.sv
`timescale 1ns/1ps
module tb_int_to_float_scheduler;

    localparam int NR = 4;

    logic          clk;
    logic          reset;
    logic          cfg_fixed_priority;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR*32-1:0] req_data;
    logic          res_valid;
    logic [1:0]    res_id;
    logic [31:0]   res_data;
    logic          busy;

    logic [2:0]    req3_valid;
    logic [2:0]    req3_ready;
    logic [95:0]   req3_data;
    logic          res3_valid;
    logic [1:0]    res3_id;
    logic [31:0]   res3_data;
    logic          busy3;

    int checks   = 0;
    int failures = 0;

    int_to_float_scheduler #(.NUM_REQ(NR)) dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_fixed_priority (cfg_fixed_priority),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_data           (req_data),
        .res_valid          (res_valid),
        .res_id             (res_id),
        .res_data           (res_data),
        .busy               (busy)
    );

    int_to_float_scheduler #(.NUM_REQ(3)) dut3 (
        .clk                (clk),
        .reset              (reset),
        .cfg_fixed_priority (1'b0),
        .req_valid          (req3_valid),
        .req_ready          (req3_ready),
        .req_data           (req3_data),
        .res_valid          (res3_valid),
        .res_id             (res3_id),
        .res_data           (res3_data),
        .busy               (busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int unsigned id;
        logic [31:0] value;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req3_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rr_data(input int id);
        logic [31:0] t [4];
        t[0] = 32'd100; t[1] = 32'hFFFF_FFFF; t[2] = 32'd0; t[3] = 32'd16777216;
        return t[id];
    endfunction

    function automatic logic [31:0] rr_exp(input int id);
        logic [31:0] t [4];
        t[0] = 32'h42C8_0000; t[1] = 32'hBF80_0000; t[2] = 32'h0000_0000; t[3] = 32'h4B80_0000;
        return t[id];
    endfunction

    initial begin
        reset = 1'b1;
        cfg_fixed_priority = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req3_valid = '0;
        req3_data  = '0;

        vecs[0]  = '{0, 32'd1,          32'h3F80_0000};
        vecs[1]  = '{1, 32'd100,        32'h42C8_0000};
        vecs[2]  = '{2, 32'hFFFF_FFFF,  32'hBF80_0000};
        vecs[3]  = '{3, 32'd0,          32'h0000_0000};
        vecs[4]  = '{0, 32'd16777216,   32'h4B80_0000};
        vecs[5]  = '{1, 32'd7,          32'h40E0_0000};
        vecs[6]  = '{2, -32'sd100,      32'hC2C8_0000};
        vecs[7]  = '{3, 32'h7FFF_FFFF,  32'h4F00_0000};
        vecs[8]  = '{0, 32'h8000_0000,  32'hCF00_0000};
        vecs[9]  = '{1, 32'd16777217,   32'h4B80_0000};
        vecs[10] = '{2, 32'd16777219,   32'h4B80_0002};

        // Reset state: ready gated during reset, outputs cleared after.
        tick();
        req_valid = 4'b1111;
        #1;
        check("ready_in_reset", req_ready, 0);
        req_valid = '0;
        tick();
        reset = 1'b0;
        check("reset_res_valid", res_valid, 0);
        check("reset_res_id", res_id, 0);
        check("reset_busy", busy, 0);

        // Single-request vectors: latency 5, busy window, id and value.
        for (int v = 0; v < 11; v++) begin
            req_valid = 4'b0001 << vecs[v].id;
            req_data[vecs[v].id*32 +: 32] = vecs[v].value;
            #1;
            check($sformatf("vec%0d_ready", v), req_ready, 4'b0001 << vecs[v].id);
            tick();
            req_valid = '0;
            for (int c = 1; c <= 4; c++) begin
                if (v == 0) begin
                    check($sformatf("single_busy_c%0d", c), busy, 1);
                    check($sformatf("single_early_c%0d", c), res_valid, 0);
                end
                tick();
            end
            check($sformatf("vec%0d_res_valid", v), res_valid, 1);
            check($sformatf("vec%0d_res_id", v), res_id, vecs[v].id);
            check($sformatf("vec%0d_res_data", v), res_data, vecs[v].expected);
            if (v == 0) check("single_busy_c5", busy, 1);
            tick();
            check($sformatf("vec%0d_res_pulse", v), res_valid, 0);
            if (v == 0) check("single_busy_c6", busy, 0);
        end

        // Round-robin from reset with all requesters valid; NUM_REQ=3 build alongside.
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = rr_data(i);
        for (int k = 0; k < 15; k++) begin
            req_valid  = (k < 8) ? 4'b1111 : 4'b0000;
            req3_valid = (k < 6) ? 3'b111 : 3'b000;
            #1;
            if (k < 8) check($sformatf("rr_grant_k%0d", k), req_ready, 4'b0001 << (k % 4));
            if (k < 6) check($sformatf("rr3_grant_k%0d", k), req3_ready, 3'b001 << (k % 3));
            if (k >= 5 && k < 13) begin
                check($sformatf("rr_res_valid_k%0d", k), res_valid, 1);
                check($sformatf("rr_res_id_k%0d", k), res_id, (k - 5) % 4);
                check($sformatf("rr_res_data_k%0d", k), res_data, rr_exp((k - 5) % 4));
            end else begin
                check($sformatf("rr_res_idle_k%0d", k), res_valid, 0);
            end
            tick();
        end

        // Fixed priority then back to round-robin with the held pointer.
        do_reset();
        cfg_fixed_priority = 1'b1;
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("fp_grant_k%0d", k), req_ready, 4'b0010);
            tick();
        end
        cfg_fixed_priority = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("fp_to_rr_k%0d", k), req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 6; k++) tick();

        // Reset while a conversion is in flight discards it.
        do_reset();
        req_data[2*32 +: 32] = -32'sd100;
        req_valid = 4'b0100;
        #1;
        check("flush_issue_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("flush_busy_inflight", busy, 1);
        tick();
        reset = 1'b1;
        req_valid = 4'b0001;
        #1;
        check("flush_ready_in_reset", req_ready, 0);
        tick();
        reset = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("flush_no_result_k%0d", k), res_valid, 0);
            check($sformatf("flush_busy_k%0d", k), busy, 0);
            tick();
        end
        req_data[0 +: 32] = 32'd7;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick();
        check("post_flush_valid", res_valid, 1);
        check("post_flush_id", res_id, 0);
        check("post_flush_data", res_data, 32'h40E0_0000);

        // Idle gaps: issues at 0, 2, 3 give results exactly at 5, 7, 8.
        do_reset();
        req_data[1*32 +: 32] = 32'd3;
        for (int k = 0; k < 11; k++) begin
            req_valid = (k == 0 || k == 2 || k == 3) ? 4'b0010 : 4'b0000;
            #1;
            check($sformatf("gap_res_valid_k%0d", k), res_valid, (k == 5 || k == 7 || k == 8) ? 1 : 0);
            if (k == 5 || k == 7 || k == 8) begin
                check($sformatf("gap_res_data_k%0d", k), res_data, 32'h4040_0000);
                check($sformatf("gap_res_id_k%0d", k), res_id, 1);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
